// File: rtl/qspi_ram_if.sv
// Pin bundle between a quad-SPI RAM initiator and the RAM-side responder.
`timescale 1ns/1ps
interface qspi_ram_if;
   logic       ram_csn;
   logic       ram_clk;
   logic [3:0] ram_io_i;
   logic [1:0] ram_bank;
   logic [3:0] ram_io_o;
   logic [3:0] ram_io_oe;

   modport master (
      output ram_csn, ram_clk, ram_io_i, ram_bank,
      input  ram_io_o, ram_io_oe
   );

   modport slave (
      input  ram_csn, ram_clk, ram_io_i, ram_bank,
      output ram_io_o, ram_io_oe
   );
endinterface

// File: rtl/qspi_ram_responder.sv
// QPI PSRAM stand-in: oversamples the initiator pins on clk, decodes quad
// read (0xEB) and quad write (0x38) and serves them from a byte array.
`timescale 1ns/1ps
module qspi_ram_responder #(
   parameter int ADDR_W = 10,
   parameter int DUMMY  = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   qspi_ram_if.slave  bus,
   output logic       busy,
   output logic       err
);

   localparam int SH_W  = (ADDR_W - 2 > 8) ? ADDR_W - 2 : 8;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
   } state_t;

   // sampled pins and registered edge events
   logic        csn_s, clk_s, clk_d;
   logic [3:0]  io_s;
   logic [1:0]  bank_s;
   logic        rise_reg, fall_reg;
   logic [3:0]  nib_reg;
   logic [1:0]  ev_bank_reg;

   state_t              state_reg, state_next;
   logic [7:0]          cnt_reg, cnt_next;
   logic [SH_W-1:0]     shift_reg, shift_next;
   logic                is_wr_reg, is_wr_next;
   logic [ADDR_W-1:0]   index_reg, index_next;
   logic                phase_reg, phase_next;
   logic [3:0]          hi_reg, hi_next;
   logic [7:0]          wr_data_reg, wr_data_next;
   logic                wr_pend_reg, wr_pend_next;
   logic [3:0]          io_o_reg, io_o_next;
   logic                oe_reg, oe_next;
   logic                err_reg, err_next;

   logic [7:0]          mem [0:DEPTH-1];
   logic [7:0]          rd_data_reg;
   logic [SH_W-1:0]     shifted;

   // Newest nibble appended to the command/address shift register.
   assign shifted = SH_W'({shift_reg, nib_reg});

   // Increment within the bank: the two bank bits never change.
   function automatic logic [ADDR_W-1:0] next_index(input logic [ADDR_W-1:0] i);
      return {i[ADDR_W-1 -: 2], i[ADDR_W-3:0] + 1'b1};
   endfunction

   // Input register, then a second stage that turns ram_clk transitions into
   // one-cycle events carrying the nibble and bank seen at that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csn_s       <= 1'b1;
         clk_s       <= 1'b0;
         clk_d       <= 1'b0;
         io_s        <= 4'h0;
         bank_s      <= 2'b00;
         rise_reg    <= 1'b0;
         fall_reg    <= 1'b0;
         nib_reg     <= 4'h0;
         ev_bank_reg <= 2'b00;
      end else begin
         csn_s       <= bus.ram_csn;
         clk_s       <= bus.ram_clk;
         io_s        <= bus.ram_io_i;
         bank_s      <= bus.ram_bank;
         clk_d       <= clk_s;
         rise_reg    <= clk_s & ~clk_d;
         fall_reg    <= ~clk_s & clk_d;
         nib_reg     <= io_s;
         ev_bank_reg <= bank_s;
      end
   end

   // Protocol state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= 8'd0;
         shift_reg   <= '0;
         is_wr_reg   <= 1'b0;
         index_reg   <= '0;
         phase_reg   <= 1'b0;
         hi_reg      <= 4'h0;
         wr_data_reg <= 8'h00;
         wr_pend_reg <= 1'b0;
         io_o_reg    <= 4'h0;
         oe_reg      <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         shift_reg   <= shift_next;
         is_wr_reg   <= is_wr_next;
         index_reg   <= index_next;
         phase_reg   <= phase_next;
         hi_reg      <= hi_next;
         wr_data_reg <= wr_data_next;
         wr_pend_reg <= wr_pend_next;
         io_o_reg    <= io_o_next;
         oe_reg      <= oe_next;
         err_reg     <= err_next;
      end
   end

   // Next-state and datapath decode; deselect overrides every state.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      shift_next   = shift_reg;
      is_wr_next   = is_wr_reg;
      index_next   = index_reg;
      phase_next   = phase_reg;
      hi_next      = hi_reg;
      wr_data_next = wr_data_reg;
      wr_pend_next = 1'b0;
      io_o_next    = io_o_reg;
      oe_next      = oe_reg;
      err_next     = err_reg;

      // a committed write byte advances the pointer in the commit cycle
      if (wr_pend_reg)
         index_next = next_index(index_reg);

      if (csn_s) begin
         state_next = S_IDLE;
         oe_next    = 1'b0;
         io_o_next  = 4'h0;
         phase_next = 1'b0;
         cnt_next   = 8'd0;
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               state_next = S_CMD;
               cnt_next   = 8'd0;
               phase_next = 1'b0;
            end
            S_CMD: if (rise_reg) begin
               shift_next = shifted;
               if (cnt_reg == 8'd1) begin
                  cnt_next = 8'd0;
                  if (shifted[7:0] == 8'hEB) begin
                     is_wr_next = 1'b0;
                     state_next = S_ADDR;
                  end else if (shifted[7:0] == 8'h38) begin
                     is_wr_next = 1'b1;
                     state_next = S_ADDR;
                  end else begin
                     err_next   = 1'b1;
                     state_next = S_IGNORE;
                  end
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end
            S_ADDR: if (rise_reg) begin
               shift_next = shifted;
               if (cnt_reg == 8'd5) begin
                  cnt_next   = 8'd0;
                  index_next = {ev_bank_reg, shifted[ADDR_W-3:0]};
                  if (is_wr_reg)
                     state_next = S_WDATA;
                  else if (DUMMY == 0)
                     state_next = S_RDATA;
                  else
                     state_next = S_DUMMY;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end
            S_DUMMY: if (rise_reg) begin
               if (cnt_reg == 8'(DUMMY - 1)) begin
                  cnt_next   = 8'd0;
                  state_next = S_RDATA;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end
            S_RDATA: if (fall_reg) begin
               oe_next = 1'b1;
               if (!phase_reg) begin
                  io_o_next  = rd_data_reg[7:4];
                  phase_next = 1'b1;
               end else begin
                  io_o_next  = rd_data_reg[3:0];
                  phase_next = 1'b0;
                  index_next = next_index(index_reg);
               end
            end
            S_WDATA: if (rise_reg) begin
               if (!phase_reg) begin
                  hi_next    = nib_reg;
                  phase_next = 1'b1;
               end else begin
                  wr_data_next = {hi_reg, nib_reg};
                  wr_pend_next = 1'b1;
                  phase_next   = 1'b0;
               end
            end
            S_IGNORE: ;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Byte array with registered read; contents deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_pend_reg)
         mem[index_reg] <= wr_data_reg;
      rd_data_reg <= mem[index_reg];
   end

   assign bus.ram_io_o = io_o_reg;
   assign busy         = (state_reg != S_IDLE);
   assign err          = err_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_oe
         assign bus.ram_io_oe[gi] = oe_reg;
      end
   endgenerate

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Directed + randomized bench: drives the QPI pins like an initiator and
// checks read data against a flat byte-array model of the RAM.
`timescale 1ns/1ps
module tb_qspi_ram_responder;
   localparam int ADDR_W = 10;
   localparam int DUMMY  = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, err;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] model [0:(1<<ADDR_W)-1];

   qspi_ram_if bus();

   qspi_ram_responder #(.ADDR_W(ADDR_W), .DUMMY(DUMMY)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory index from the RAM's point of view: bank plus 8 low address bits.
   function automatic int midx(input logic [1:0] b, input logic [23:0] a, input int off);
      return int'(b) * 256 + ((int'(a[7:0]) + off) % 256);
   endfunction

   // One ram_clk period: low for 5 clk (data set, outputs sampled at the end),
   // then high for 3 clk.
   task automatic tick(input logic [3:0] d, output logic [3:0] o, output logic [3:0] oe);
      bus.ram_clk  = 1'b0;
      bus.ram_io_i = d;
      repeat (5) @(negedge clk);
      o  = bus.ram_io_o;
      oe = bus.ram_io_oe;
      bus.ram_clk = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send(input logic [3:0] d);
      logic [3:0] o, e;
      tick(d, o, e);
   endtask

   task automatic start_txn(input logic [7:0] cmd, input logic [23:0] addr, input logic [1:0] bank);
      bus.ram_bank = bank;
      bus.ram_clk  = 1'b0;
      bus.ram_csn  = 1'b0;
      @(negedge clk);
      send(cmd[7:4]);
      send(cmd[3:0]);
      for (int i = 5; i >= 0; i--) send(addr[i*4 +: 4]);
   endtask

   task automatic stop_txn();
      bus.ram_clk = 1'b0;
      bus.ram_csn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic write_txn(input logic [23:0] addr, input logic [1:0] bank, input logic [7:0] data[$]);
      start_txn(8'h38, addr, bank);
      foreach (data[i]) begin
         send(data[i][7:4]);
         send(data[i][3:0]);
         model[midx(bank, addr, i)] = data[i];
      end
      stop_txn();
      $display("write bank=%0d addr=%06h bytes=%0d", bank, addr, data.size());
   endtask

   task automatic read_txn(input string tag, input logic [23:0] addr, input logic [1:0] bank, input int n);
      logic [3:0] o, e;
      logic [7:0] exp;
      start_txn(8'hEB, addr, bank);
      repeat (DUMMY) send(4'h0);
      for (int i = 0; i < n; i++) begin
         exp = model[midx(bank, addr, i)];
         tick(4'h0, o, e);
         check({tag, "_hi"}, {4'h0, o}, {4'h0, exp[7:4]});
         check({tag, "_oe"}, {4'h0, e}, 8'h0F);
         tick(4'h0, o, e);
         check({tag, "_lo"}, {4'h0, o}, {4'h0, exp[3:0]});
      end
      stop_txn();
      check({tag, "_oe_idle"}, {4'h0, bus.ram_io_oe}, 8'h00);
      $display("read  bank=%0d addr=%06h bytes=%0d", bank, addr, n);
   endtask

   initial begin
      logic [7:0]  q[$];
      logic [3:0]  o, e;
      logic [1:0]  b;
      logic [23:0] a;
      logic [7:0]  d1, d2;
      int          n;

      bus.ram_csn  = 1'b1;
      bus.ram_clk  = 1'b0;
      bus.ram_io_i = 4'h0;
      bus.ram_bank = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_io_o", {4'h0, bus.ram_io_o}, 8'h00);
      check("rst_oe",   {4'h0, bus.ram_io_oe}, 8'h00);
      check("rst_busy", {7'h0, busy}, 8'h00);
      check("rst_err",  {7'h0, err}, 8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // preload every bank with known random contents
      for (int bk = 0; bk < 4; bk++) begin
         q.delete();
         for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
         write_txn(24'h000000, 2'(bk), q);
      end

      // write then read back
      q = {8'hA5, 8'h3C};
      write_txn(24'h000010, 2'd0, q);
      read_txn("wr_rd", 24'h000010, 2'd0, 2);
      check("err_clean", {7'h0, err}, 8'h00);

      // wrap within the bank
      q = {8'h11, 8'h22};
      write_txn(24'h0000FF, 2'd1, q);
      read_txn("wrap", 24'h0000FF, 2'd1, 2);
      read_txn("wrap_b1_00", 24'h000000, 2'd1, 1);

      // bank isolation
      q = {8'h00};
      write_txn(24'h000005, 2'd3, q);
      q = {8'h77};
      write_txn(24'h000005, 2'd2, q);
      read_txn("bank3", 24'h000005, 2'd3, 1);
      read_txn("bank2", 24'h000005, 2'd2, 1);

      // randomized traffic, upper address bits randomized too
      for (int t = 0; t < 20; t++) begin
         b = 2'($urandom_range(0, 3));
         a = 24'($urandom);
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 1) begin
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            write_txn(a, b, q);
         end else begin
            read_txn("rand", a, b, n);
         end
      end

      // unsupported command
      bus.ram_bank = 2'd0;
      bus.ram_csn  = 1'b0;
      @(negedge clk);
      send(4'h9);
      send(4'hF);
      check("bad_err", {7'h0, err}, 8'h01);
      for (int i = 0; i < 8; i++) begin
         tick(4'($urandom), o, e);
         check("bad_oe", {4'h0, e}, 8'h00);
      end
      bus.ram_clk = 1'b0;
      bus.ram_csn = 1'b1;
      @(negedge clk);
      check("bad_busy_1", {7'h0, busy}, 8'h01);
      @(negedge clk);
      check("bad_busy_2", {7'h0, busy}, 8'h00);
      repeat (2) @(negedge clk);
      $display("badcmd 9F");
      read_txn("after_bad", 24'h000010, 2'd0, 2);
      check("err_sticky", {7'h0, err}, 8'h01);

      // deselect mid-read after one nibble
      a = 24'h000042;
      start_txn(8'hEB, a, 2'd1);
      repeat (DUMMY) send(4'h0);
      tick(4'h0, o, e);
      check("part_hi", {4'h0, o}, {4'h0, model[midx(2'd1, a, 0)][7:4]});
      bus.ram_clk = 1'b0;
      bus.ram_csn = 1'b1;
      @(negedge clk);
      check("part_oe_1", {4'h0, bus.ram_io_oe}, 8'h0F);
      @(negedge clk);
      check("part_oe_2", {4'h0, bus.ram_io_oe}, 8'h00);
      @(negedge clk);
      $display("read  bank=1 addr=%06h aborted after one nibble", a);
      read_txn("restart", a, 2'd1, 1);

      // reset in the middle of a write: first byte kept, partial second lost
      a  = 24'h000080;
      d1 = 8'(model[midx(2'd2, a, 0)] ^ 8'h5A);
      d2 = 8'(model[midx(2'd2, a, 1)] ^ 8'hC3);
      start_txn(8'h38, a, 2'd2);
      send(d1[7:4]);
      send(d1[3:0]);
      send(d2[7:4]);
      model[midx(2'd2, a, 0)] = d1;
      rst_n = 1'b0;
      #1;
      check("mrst_io_o", {4'h0, bus.ram_io_o}, 8'h00);
      check("mrst_oe",   {4'h0, bus.ram_io_oe}, 8'h00);
      check("mrst_busy", {7'h0, busy}, 8'h00);
      check("mrst_err",  {7'h0, err}, 8'h00);
      @(negedge clk);
      bus.ram_csn = 1'b1;
      bus.ram_clk = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      $display("write bank=2 addr=%06h interrupted by reset", a);
      read_txn("mrst", a, 2'd2, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/qspi_ram_responder.md
# qspi_ram_responder

QPI PSRAM responder: the memory-side end of the quad-SPI RAM interface that the main design drives. It oversamples the `ram_clk`, `ram_csn` and `ram_io` pins with its own system clock. It decodes quad-read and quad-write transactions and serves them from an internal byte array. It is used as the RAM stand-in on FPGA test rigs and in simulation benches, wired pin-for-pin to the initiator's uio bundle.

## Interface

Parameters:
- `ADDR_W`, default 10: internal memory holds 2^`ADDR_W` bytes; must be at least 3.
- `DUMMY`, default 6: number of `ram_clk` rising edges between the last address nibble and the first read-data nibble.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ram_csn`  in  1  chip select, active low.
- `ram_clk`  in  1  serial clock from the initiator.
- `ram_io_i`  in  4  quad data from the initiator; bit k is io_k.
- `ram_bank`  in  2  bank select; forms the top two bits of the memory index.
- `ram_io_o`  out  4  quad data driven to the initiator.
- `ram_io_oe`  out  4  output enable, all bits equal; 1 means the responder drives.
- `busy`  out  1  high while a transaction is decoded (state is not IDLE).
- `err`  out  1  sticky flag: an unsupported command was received.

## Operation

Input stage:
- `ram_csn`, `ram_clk`, `ram_io_i` and `ram_bank` are each registered once on `clk`; call these the sampled signals.
- A rise event is a cycle where sampled `ram_clk` is 1 and its previous value was 0. A fall event is the reverse.
- All protocol logic uses the sampled signals only.

Framing:
- All phases are QPI: 4 bits per `ram_clk` rising edge, most significant nibble first.
- Command: 2 nibbles. 0xEB selects quad read; 0x38 selects quad write. Any other value sets `err` and moves to IGNORE.
- Address: 6 nibbles, 24 bits. The memory index is {`ram_bank` sampled at the 6th address nibble, addr[`ADDR_W`-3:0]}. Higher address bits are ignored.

State machine and transitions:
- IDLE → CMD when sampled `ram_csn` goes low.
- CMD → ADDR after 2 nibbles.
- ADDR → DUMMY (read) or WDATA (write) after 6 nibbles.
- DUMMY → RDATA after `DUMMY` rise events.
- RDATA and WDATA continue until deselect. IGNORE waits for deselect.
- From any state, sampled `ram_csn` = 1 returns to IDLE on the next `clk`. This also forces `ram_io_oe` to 0 and drops a pending partial byte.

Read:
- On each fall event in RDATA (the first being the fall after the last dummy rise), `ram_io_o` takes the next nibble: high nibble of mem[index], then low nibble.
- The index increments after the low nibble and wraps modulo 2^(`ADDR_W`-2) within the bank.
- `ram_io_oe` becomes 4'b1111 with the first nibble.

Write:
- The nibble on a rise event in WDATA is stored as high, then low.
- The byte is written to mem[index] in the cycle after the low-nibble rise event; then the index increments with the same wrap rule as read.
- A lone high nibble at deselect is discarded.

Memory and flags:
- Memory contents are not reset.
- `err` clears only on reset.

## Timing

- Reset values: `ram_io_o` = 0, `ram_io_oe` = 0, `busy` = 0, `err` = 0, state IDLE.
- Pin-to-event latency: 2 `clk` cycles (input register plus edge detect). Output nibble update: 1 `clk` cycle after the fall event, so 3 cycles after the pin edge.
- Requirements on the initiator: `ram_clk` high ≥ 2 `clk` cycles and low ≥ 4 `clk` cycles; `ram_csn` high ≥ 2 `clk` cycles between transactions. With these, read data is stable ≥ 1 `clk` before the next pin rise.
- `ram_io_oe` falls 2 `clk` cycles after the `ram_csn` pin rises.
- Simultaneous `ram_csn` rise and a rise event: deselect wins and the nibble is ignored.
- Reset mid-transaction: immediate return to reset values. A write whose byte is not yet committed is lost; bytes already written are kept.

## Test plan

- Write then read: 0x38, addr 0x000010, bank 0, data A5 3C, deselect. Then 0xEB, addr 0x000010 with `DUMMY`=6. Expected read nibbles: A,5,3,C; `ram_io_oe` = 1111 from the first read fall event; `err` = 0.
- Wrap: with `ADDR_W`=10, write 0x11 0x22 at addr 0x0000FF, bank 1, then read 2 bytes from 0x0000FF, bank 1. Expected 11, 22, and mem[{1,0x00}] = 0x22.
- Bank isolation: write 0x77 at addr 5, bank 2, then read addr 5, bank 3. Expected: not 0x77 (preloaded 0x00); reading addr 5, bank 2 returns 0x77.
- Bad command 0x9F: `err` goes to 1, `ram_io_oe` stays 0 through 8 further edges, `busy` drops 2 cycles after deselect. A following valid read still works and `err` stays 1.
- Deselect mid-read after 1 nibble: `ram_io_oe` = 0 within 2 cycles. A fresh read from the same address restarts at the high nibble.
- Reset mid-write after 3 nibbles: all outputs take their reset values. The first byte is committed and the partial second byte is absent.
